// File: rtl/instr_fetch_if.sv
// instr_fetch_if: decoder-side valid/ready handshake carrying instruction byte and its fetch address
interface instr_fetch_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              ir_valid;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_addr;
  logic              ir_ready;
  modport master (output ir_valid, ir_data, ir_addr, input ir_ready);
  modport slave  (input ir_valid, ir_data, ir_addr, output ir_ready);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven ROM fetch engine with prefetch FIFO, jump flush and halt
module instr_fetch #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] addr_pc,
  output logic              pc_write,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] jump_addr,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  instr_fetch_if.master     ir
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef enum logic [1:0] {START, RUN, HALT} state_t;
  state_t state, state_next;
  logic inflight, jmp, issue, push, pop;
  logic [ADDR_W-1:0] req_addr;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [DATA_W+ADDR_W-1:0] mem [BUF_DEPTH];
  assign ir.ir_valid = count != '0;
  assign ir.ir_data  = ir.ir_valid ? mem[rd_ptr][DATA_W+ADDR_W-1:ADDR_W] : '0;
  assign ir.ir_addr  = ir.ir_valid ? mem[rd_ptr][ADDR_W-1:0] : '0;
  always_comb begin
    state_next = state;
    state_next = state == START ? RUN : halt ? HALT : RUN;
  end
  // a pop in the same cycle frees a slot, keeping one fetch per cycle when streaming
  always_comb begin
    jmp       = jump_req && state != START;
    pop       = ir.ir_valid && ir.ir_ready && !jmp;
    push      = inflight && !jmp;
    issue     = state == RUN && !jump_req &&
                ((CNT_W+1)'(count) + (CNT_W+1)'(inflight)) < ((CNT_W+1)'(BUF_DEPTH) + (CNT_W+1)'(pop));
    pc_write  = jmp || issue;
    pc_sel    = jmp;
    jump_addr = jmp ? jump_target : '0;
    rom_en    = issue;
    rom_addr  = issue ? addr_pc : '0;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= START;
      inflight <= 1'b0;
      req_addr <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (issue) req_addr <= addr_pc;
      if (jmp) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {rom_data, req_addr};
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized fetch/jump/halt stimulus against a queue-based model of outstanding fetches
module tb_instr_fetch;
  localparam int DEPTH = 2;
  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] pc, jump_addr, rom_addr, jump_target = 8'h0, rom_data = 8'h0;
  logic pc_write, pc_sel, rom_en, jump_req = 1'b0, halt = 1'b0;
  int errors = 0, checks = 0, cyc = 0, age = 0, rel = 0;
  logic halt_prev = 1'b0;
  logic [7:0] nxt = 8'h0;
  typedef struct { logic [7:0] a; int c; } ent_t;
  ent_t q[$];
  logic [7:0] got_a[$], got_d[$];
  int got_c[$];

  instr_fetch_if #(.DATA_W(8), .ADDR_W(8)) irf();
  instr_fetch #(.DATA_W(8), .ADDR_W(8), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .addr_pc(pc), .pc_write(pc_write), .pc_sel(pc_sel),
    .jump_addr(jump_addr), .jump_req(jump_req), .jump_target(jump_target), .halt(halt),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .ir(irf)
  );

  always #5 clk = ~clk;

  // PC register and ROM environment; ROM returns garbage on cycles without a read
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) pc <= 8'h0;
    else if (pc_write) pc <= pc_sel ? jump_addr : 8'(pc + 8'd1);
  always_ff @(posedge clk) rom_data <= rom_en ? (rom_addr ^ 8'hA5) : 8'($urandom);

  function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endfunction

  // q holds every fetch issued since the last flush and not yet accepted by the decoder
  initial begin : model
    bit run, jmp, v, pop, iss;
    logic [7:0] ha;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        q.delete();
        age = 0;
        nxt = 8'h0;
        halt_prev = 1'b0;
        chk("reset_outs", {pc_write, pc_sel, rom_en, irf.ir_valid, jump_addr, rom_addr, irf.ir_data, irf.ir_addr}, 64'h0);
      end else begin
        run = age == 1 || (age >= 2 && !halt_prev);
        jmp = jump_req && age >= 1;
        ha  = q.size() > 0 ? q[0].a : 8'h0;
        v   = q.size() > 0 && q[0].c + 2 <= cyc;
        pop = v && irf.ir_ready && !jmp;
        iss = !jump_req && run && (q.size() - int'(pop)) < DEPTH;
        chk("ir_valid", irf.ir_valid, v);
        chk("rom_en", rom_en, iss);
        chk("pc_write", pc_write, jmp || iss);
        chk("pc_sel", pc_sel, jmp);
        chk("jump_addr", jump_addr, jmp ? jump_target : 8'h0);
        chk("rom_addr", rom_addr, iss ? nxt : 8'h0);
        chk("ir_addr", irf.ir_addr, v ? ha : 8'h0);
        chk("ir_data", irf.ir_data, v ? (ha ^ 8'hA5) : 8'h0);
        if (irf.ir_valid && irf.ir_ready && !jmp) begin
          got_a.push_back(irf.ir_addr);
          got_d.push_back(irf.ir_data);
          got_c.push_back(cyc);
        end
        if (jmp) begin
          q.delete();
          nxt = jump_target;
        end else begin
          if (pop) void'(q.pop_front());
          if (iss) begin
            q.push_back('{nxt, cyc});
            nxt++;
          end
        end
        halt_prev = halt;
        age++;
      end
      cyc++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    got_a.delete();
    got_d.delete();
    got_c.delete();
  endtask

  task automatic do_reset(input logic rdy);
    rstn = 1'b0;
    jump_req = 1'b0;
    halt = 1'b0;
    irf.ir_ready = rdy;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    rel = cyc;
    clear_log();
  endtask

  task automatic check_startup(input string p);
    repeat (8) tick();
    chk({p, "_count"}, 64'(got_a.size() >= 5), 64'h1);
    chk({p, "_latency"}, got_c.size() > 0 ? 64'(got_c[0] - rel) : 64'hFF, 64'd3);
    chk({p, "_d0"}, got_d.size() > 0 ? 64'(got_d[0]) : 64'hFFF, 64'hA5);
    chk({p, "_d1"}, got_d.size() > 1 ? 64'(got_d[1]) : 64'hFFF, 64'hA4);
    for (int k = 0; k < 5 && k < got_a.size(); k++) begin
      chk({p, "_addr"}, got_a[k], 64'(k));
      chk({p, "_data"}, got_d[k], 64'(8'(k) ^ 8'hA5));
      chk({p, "_cycle"}, 64'(got_c[k] - rel), 64'(3 + k));
    end
  endtask

  initial begin
    int n_iss;
    logic [7:0] p;
    irf.ir_ready = 1'b1;
    // startup stream with decoder always ready
    do_reset(1'b1);
    check_startup("s1");
    // decoder stalled: fetch stops once the buffer is committed
    do_reset(1'b0);
    n_iss = 0;
    repeat (8) begin
      tick();
      n_iss += int'(rom_en);
    end
    chk("s2_issues", 64'(n_iss), 64'd2);
    chk("s2_pc_hold", pc, 64'h02);
    chk("s2_head", irf.ir_data, 64'hA5);
    irf.ir_ready = 1'b1;
    repeat (6) tick();
    chk("s2_count", 64'(got_a.size() >= 4), 64'h1);
    for (int k = 0; k < 4 && k < got_a.size(); k++) chk("s2_order", got_a[k], 64'(k));
    // jump with a buffered byte and a read in flight
    do_reset(1'b0);
    repeat (3) tick();
    chk("s3_pre_valid", irf.ir_valid, 64'h1);
    jump_req = 1'b1;
    jump_target = 8'h40;
    clear_log();
    #1;
    chk("s3_jump_outs", {pc_sel, pc_write, rom_en, jump_addr}, {1'b1, 1'b1, 1'b0, 8'h40});
    tick();
    jump_req = 1'b0;
    #1;
    chk("s3_flushed", irf.ir_valid, 64'h0);
    irf.ir_ready = 1'b1;
    repeat (6) tick();
    chk("s3_first", got_a.size() > 0 ? 64'(got_a[0]) : 64'hFFF, 64'h40);
    chk("s3_second", got_a.size() > 1 ? 64'(got_a[1]) : 64'hFFF, 64'h41);
    // address wrap through 0xFF
    tick();
    jump_req = 1'b1;
    jump_target = 8'hFE;
    clear_log();
    tick();
    jump_req = 1'b0;
    repeat (7) tick();
    chk("s4_seq", got_a.size() >= 4 ? {got_a[0], got_a[1], got_a[2], got_a[3]} : 64'h0, 64'hFEFF0001);
    chk("s4_data", got_d.size() >= 4 ? {got_d[0], got_d[1], got_d[2], got_d[3]} : 64'h0, 64'h5B5AA5A4);
    // halt mid-stream, drain, resume at held PC
    tick();
    halt = 1'b1;
    clear_log();
    tick();
    chk("s5_no_issue", rom_en, 64'h0);
    p = pc;
    repeat (4) tick();
    chk("s5_still_idle", rom_en, 64'h0);
    chk("s5_drained", irf.ir_valid, 64'h0);
    chk("s5_pc_held", pc, 64'(p));
    halt = 1'b0;
    repeat (8) tick();
    chk("s5_count", 64'(got_a.size() >= 6), 64'h1);
    for (int i = 0; i + 1 < got_a.size(); i++) chk("s5_contig", got_a[i + 1], 64'(8'(got_a[i] + 8'd1)));
    // asynchronous reset with a non-empty buffer
    irf.ir_ready = 1'b0;
    tick();
    tick();
    chk("s6_pre_valid", irf.ir_valid, 64'h1);
    #2 rstn = 1'b0;
    #1;
    chk("s6_async", {pc_write, rom_en, irf.ir_valid, irf.ir_data, irf.ir_addr}, 64'h0);
    do_reset(1'b1);
    check_startup("s6");
    // random traffic: stalls, halts, jumps
    do_reset(1'b1);
    for (int n = 0; n < 3000; n++) begin
      tick();
      irf.ir_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 19) == 0) halt = !halt;
      jump_req = $urandom_range(0, 15) == 0;
      jump_target = 8'($urandom);
    end
    jump_req = 1'b0;
    halt = 1'b0;
    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
